// File: rtl/mod12_chk_pkg.sv
// Shared types and the reference mod-12 counter model for the sequence checker.
// The optional sticky-error feature is enabled with MOD12_CHK_STICKY_EN (see top).
package mod12_chk_pkg;

  localparam logic [3:0] MOD_MAX = 4'd11;

  typedef enum logic [1:0] {
    EV_WRAP         = 2'd0,
    EV_MISMATCH     = 2'd1,
    EV_ILLEGAL_LOAD = 2'd2,
    EV_RSVD         = 2'd3
  } ev_type_e;

  typedef struct packed {
    ev_type_e   typ;
    logic [3:0] val;
  } ev_rec_t;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_TRACK = 1'b1
  } chk_state_e;

  // Load wins over direction; out-of-range values simply step by one.
  function automatic logic [3:0] next_count(input logic [3:0] dout,
                                            input logic       load,
                                            input logic       mode,
                                            input logic [3:0] data_in);
    logic [3:0] nxt;
    if (load) begin
      nxt = data_in;
    end else if (mode) begin
      nxt = (dout == MOD_MAX) ? 4'd0 : dout + 4'd1;
    end else begin
      nxt = (dout == 4'd0) ? MOD_MAX : dout - 4'd1;
    end
    return nxt;
  endfunction

  function automatic logic is_wrap_step(input logic [3:0] dout,
                                        input logic       load,
                                        input logic       mode);
    logic wrap;
    if (load) begin
      wrap = 1'b0;
    end else if (mode) begin
      wrap = (dout == MOD_MAX);
    end else begin
      wrap = (dout == 4'd0);
    end
    return wrap;
  endfunction

endpackage

// File: rtl/mod12_chk_fifo.sv
// Event record FIFO: DEPTH entries, full/empty from pointers carrying an extra wrap bit.
// Push/pop must arrive already qualified by the caller.
module mod12_chk_fifo
  import mod12_chk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  ev_rec_t push_rec_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output ev_rec_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  ev_rec_t     mem_q [DEPTH];

  // Storage and pointers; reset discards every queued record at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_rec_i;
        wr_ptr_q                <= wr_ptr_q + PTR_ONE;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/mod12_seq_checker.sv
// In-line checker for a mod-12 up/down counter: predicts dout, reports events via a FIFO.
// Define MOD12_CHK_STICKY_EN to add the err_sticky output and err_clr input.
module mod12_seq_checker
  import mod12_chk_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WCNT_W = 16,
  parameter int ECNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              mode,
  input  logic [3:0]        data_in,
  input  logic [3:0]        dout,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [1:0]        ev_type,
  output logic [3:0]        ev_value,
  output logic [WCNT_W-1:0] wrap_cnt,
  output logic [ECNT_W-1:0] err_cnt,
  output logic [ECNT_W-1:0] drop_cnt
`ifdef MOD12_CHK_STICKY_EN
  ,
  output logic              err_sticky,
  input  logic              err_clr
`endif
);

  localparam logic [WCNT_W-1:0] WCNT_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};
  localparam logic [ECNT_W-1:0] ECNT_ONE = {{(ECNT_W-1){1'b0}}, 1'b1};

  chk_state_e        state_q;
  logic [3:0]        exp_q;
  logic              chk_en_q;
  logic              wrap_pred_q;
  logic [WCNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [ECNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ECNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic    ev_hit;
  ev_rec_t ev_rec;
  logic    fifo_full;
  logic    fifo_empty;
  ev_rec_t head_rec;
  logic    pop;
  logic    push;
  logic    drop;
  logic    err_ev;
  logic    wrap_ev;

  // FSM plus predictor: exp/chk_en/wrap_pred describe what the next edge must see.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PRIME;
      exp_q       <= 4'd0;
      chk_en_q    <= 1'b0;
      wrap_pred_q <= 1'b0;
    end else begin
      exp_q       <= next_count(dout, load, mode, data_in);
      chk_en_q    <= !(load && (data_in > MOD_MAX));
      wrap_pred_q <= is_wrap_step(dout, load, mode);
      case (state_q)
        ST_PRIME: state_q <= ST_TRACK;
        ST_TRACK: state_q <= ST_TRACK;
        default:  state_q <= ST_PRIME;
      endcase
    end
  end

  // Classify the current edge; first matching rule wins, at most one event.
  always_comb begin
    ev_hit     = 1'b0;
    ev_rec.typ = EV_WRAP;
    ev_rec.val = 4'd0;
    if (state_q == ST_TRACK) begin
      if (dout > MOD_MAX) begin
        ev_hit     = 1'b1;
        ev_rec.typ = EV_MISMATCH;
        ev_rec.val = dout;
      end else if (chk_en_q && (dout != exp_q)) begin
        ev_hit     = 1'b1;
        ev_rec.typ = EV_MISMATCH;
        ev_rec.val = dout;
      end else if (wrap_pred_q && (dout == exp_q)) begin
        ev_hit     = 1'b1;
        ev_rec.typ = EV_WRAP;
        ev_rec.val = dout;
      end else if (load && (data_in > MOD_MAX)) begin
        ev_hit     = 1'b1;
        ev_rec.typ = EV_ILLEGAL_LOAD;
        ev_rec.val = data_in;
      end else begin
        ev_hit = 1'b0;
      end
    end else begin
      ev_hit = 1'b0;
    end
  end

  // A full FIFO still accepts a record when its head leaves in the same cycle.
  assign pop     = ev_valid && ev_ready;
  assign push    = ev_hit && (!fifo_full || pop);
  assign drop    = ev_hit && fifo_full && !pop;
  assign wrap_ev = ev_hit && (ev_rec.typ == EV_WRAP);
  assign err_ev  = ev_hit && ((ev_rec.typ == EV_MISMATCH) || (ev_rec.typ == EV_ILLEGAL_LOAD));

  mod12_chk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_rec_i (ev_rec),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head_rec)
  );

  assign ev_valid = !fifo_empty;
  assign ev_type  = fifo_empty ? 2'd0 : 2'(head_rec.typ);
  assign ev_value = fifo_empty ? 4'd0 : head_rec.val;

  // Saturating statistics counters.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (wrap_ev && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + WCNT_ONE;
    end else begin
      wrap_cnt_d = wrap_cnt_q;
    end
    if (err_ev && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ECNT_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + ECNT_ONE;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_cnt_q <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign drop_cnt = drop_cnt_q;

`ifdef MOD12_CHK_STICKY_EN
  logic err_sticky_q;
  logic err_sticky_d;

  // Setting has priority over a same-cycle clear.
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (err_ev || drop) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end
  end

  // Sticky error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

endmodule
